// File: rtl/gh_highway_gen_pkg.sv
// rtl/gh_highway_gen_pkg.sv - shared types, lane colours and default raster geometry for the highway generator
package gh_highway_gen_pkg;

  localparam int NUM_LANES = 5;
  localparam int COORD_W   = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [23:0]        rgb_t;

  typedef enum logic [2:0] {
    LANE_GREEN  = 3'd0,
    LANE_RED    = 3'd1,
    LANE_YELLOW = 3'd2,
    LANE_BLUE   = 3'd3,
    LANE_ORANGE = 3'd4
  } lane_e;

  localparam rgb_t COLOUR_GREEN  = 24'h00FF00;
  localparam rgb_t COLOUR_RED    = 24'hFF0000;
  localparam rgb_t COLOUR_YELLOW = 24'hFFFF00;
  localparam rgb_t COLOUR_BLUE   = 24'h0000FF;
  localparam rgb_t COLOUR_ORANGE = 24'hFF8000;
  localparam rgb_t BG_COLOUR     = 24'h202020;

  localparam int DEF_H_ACTIVE   = 1280;
  localparam int DEF_H_FP       = 110;
  localparam int DEF_H_SYNC     = 40;
  localparam int DEF_H_BP       = 220;
  localparam int DEF_V_ACTIVE   = 720;
  localparam int DEF_V_FP       = 5;
  localparam int DEF_V_SYNC     = 5;
  localparam int DEF_V_BP       = 20;
  localparam int DEF_LANE_X0    = 400;
  localparam int DEF_LANE_PITCH = 100;
  localparam int DEF_GEM_W      = 80;
  localparam int DEF_GEM_H      = 24;

  function automatic rgb_t lane_colour(input lane_e lane);
    case (lane)
      LANE_GREEN:  lane_colour = COLOUR_GREEN;
      LANE_RED:    lane_colour = COLOUR_RED;
      LANE_YELLOW: lane_colour = COLOUR_YELLOW;
      LANE_BLUE:   lane_colour = COLOUR_BLUE;
      LANE_ORANGE: lane_colour = COLOUR_ORANGE;
      default:     lane_colour = BG_COLOUR;
    endcase
  endfunction

endpackage

// File: rtl/gh_highway_gen_if.sv
// rtl/gh_highway_gen_if.sv - note request handshake plus the video stream the fret detectors consume
interface gh_highway_gen_if;
  import gh_highway_gen_pkg::*;

  logic                 note_valid;
  logic [NUM_LANES-1:0] note_mask;
  logic                 note_ready;
  logic                 hsync;
  logic                 vsync;
  logic                 vde;
  logic                 frame_start;
  rgb_t                 rgb;

  // master is the generator (video source, request sink)
  modport master (
    input  note_valid, note_mask,
    output note_ready, hsync, vsync, vde, frame_start, rgb
  );

  modport slave (
    output note_valid, note_mask,
    input  note_ready, hsync, vsync, vde, frame_start, rgb
  );

endinterface

// File: rtl/gh_highway_gen_timing.sv
// rtl/gh_highway_gen_timing.sv - gh_video_timing: raster counters, registered sync/VDE decode, frame boundary strobe
module gh_video_timing
  import gh_highway_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  output coord_t o_x,
  output coord_t o_y,
  output logic   o_active,
  output logic   o_boundary,
  output logic   o_hsync,
  output logic   o_vsync,
  output logic   o_vde,
  output logic   o_frame_start
);

  localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t r_hcnt;
  coord_t r_vcnt;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_vde;
  logic   r_frame_start;

  logic   w_h_last;
  logic   w_v_last;
  logic   w_active;
  logic   w_hsync;
  logic   w_vsync;
  logic   w_first;

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);
  assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hsync  = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
  assign w_vsync  = (r_vcnt >= VS_START) && (r_vcnt < VS_END);
  assign w_first  = (r_hcnt == '0) && (r_vcnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_h_last ? '0 : r_hcnt + coord_t'(1);
      if (w_h_last) begin
        r_vcnt <= w_v_last ? '0 : r_vcnt + coord_t'(1);
      end
    end
  end

  // Decoded strobes lag the counters by one cycle, matching the registered pixel colour
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_vde         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_vde         <= w_active;
      r_frame_start <= w_first;
    end
  end

  assign o_x           = r_hcnt;
  assign o_y           = r_vcnt;
  assign o_active      = w_active;
  assign o_boundary    = w_h_last && w_v_last;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_vde         = r_vde;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/gh_highway_gen.sv
// rtl/gh_highway_gen.sv - five-lane scrolling note highway video source with spawn request slot
module gh_highway_gen
  import gh_highway_gen_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int GEM_W      = DEF_GEM_W,
  parameter int GEM_H      = DEF_GEM_H
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [3:0]           i_speed,
  gh_highway_gen_if.master     bus,
  output logic [NUM_LANES-1:0] o_busy,
  output logic [7:0]           o_dropped
);

  coord_t               w_x;
  coord_t               w_y;
  logic                 w_active;
  logic                 w_boundary;

  logic [NUM_LANES-1:0] r_busy;
  coord_t               r_gem_y [NUM_LANES];
  logic                 r_pend;
  logic [NUM_LANES-1:0] r_pend_mask;
  logic [7:0]           r_dropped;
  rgb_t                 r_rgb;

  logic [NUM_LANES-1:0] w_busy_nx;
  coord_t               w_gem_y_nx [NUM_LANES];
  logic [2:0]           w_drop_inc;
  logic [8:0]           w_drop_sum;
  logic [7:0]           w_dropped_nx;
  logic                 w_accept;
  logic [NUM_LANES-1:0] w_hit;
  rgb_t                 w_pix;

  gh_video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_active      (w_active),
    .o_boundary    (w_boundary),
    .o_hsync       (bus.hsync),
    .o_vsync       (bus.vsync),
    .o_vde         (bus.vde),
    .o_frame_start (bus.frame_start)
  );

  // Ready is gated by reset so every output reads 0 while reset is held
  assign bus.note_ready = i_enable & ~r_pend & i_rst_n;
  assign w_accept       = bus.note_valid & bus.note_ready;

  // Boundary update: advance each lane first, then try the pending spawn on it
  always_comb begin : lane_next
    logic [12:0] y_adv;
    logic        still_busy;
    w_busy_nx  = r_busy;
    w_gem_y_nx = r_gem_y;
    w_drop_inc = '0;
    y_adv      = '0;
    still_busy = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      y_adv         = {1'b0, r_gem_y[i]} + {9'd0, i_speed};
      still_busy    = r_busy[i] && (y_adv < 13'(V_ACTIVE));
      w_busy_nx[i]  = still_busy;
      if (still_busy) begin
        w_gem_y_nx[i] = y_adv[11:0];
      end
      if (r_pend && r_pend_mask[i]) begin
        if (still_busy) begin
          w_drop_inc = w_drop_inc + 3'd1;
        end else begin
          w_busy_nx[i]  = 1'b1;
          w_gem_y_nx[i] = '0;
        end
      end
    end
  end

  assign w_drop_sum   = {1'b0, r_dropped} + {6'd0, w_drop_inc};
  assign w_dropped_nx = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= '0;
      r_dropped <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_gem_y[i] <= '0;
      end
    end else if (w_boundary) begin
      if (!i_enable) begin
        r_busy <= '0;
      end else begin
        r_busy    <= w_busy_nx;
        r_gem_y   <= w_gem_y_nx;
        r_dropped <= w_dropped_nx;
      end
    end
  end

  // An accept on the boundary cycle lands after the boundary has consumed the slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend      <= 1'b0;
      r_pend_mask <= '0;
    end else if (w_accept) begin
      r_pend      <= 1'b1;
      r_pend_mask <= bus.note_mask;
    end else if (w_boundary) begin
      r_pend      <= 1'b0;
    end
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_hit[i] = r_busy[i]
              && (w_x >= coord_t'(LANE_X0 + i * LANE_PITCH))
              && (w_x <  coord_t'(LANE_X0 + i * LANE_PITCH + GEM_W))
              && (w_y >= r_gem_y[i])
              && ({1'b0, w_y} < ({1'b0, r_gem_y[i]} + 13'(GEM_H)));
    end
  end

  // Walk downward so the lowest-index lane wins an overlap
  always_comb begin
    w_pix = BG_COLOUR;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_pix = lane_colour(lane_e'(3'(i)));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= '0;
    end else if (!w_active) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= i_enable ? w_pix : BG_COLOUR;
    end
  end

  assign bus.rgb   = r_rgb;
  assign o_busy    = r_busy;
  assign o_dropped = r_dropped;

endmodule

// File: tb/tb_gh_highway_gen.sv
// tb/tb_gh_highway_gen.sv - randomized bench for gh_highway_gen against a frame-level reference model
module tb_gh_highway_gen;

  localparam int HA = 16, HFP = 2, HSW = 2, HBP = 4;
  localparam int VA = 12, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int LX0 = 1, LP = 3, GW = 2, GH = 2;
  localparam logic [23:0] BG = 24'h202020;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] speed = 4'd0;
  logic [4:0] busy;
  logic [7:0] dropped;

  logic [23:0] lane_rgb [5];

  int n_checks = 0;
  int n_errors = 0;

  int       m_gy [5];
  bit       m_busy [5];
  bit       m_pend;
  bit [4:0] m_mask;
  int       m_drop;
  int       m_p;
  int       vde_cnt;
  int       fs_cnt;

  gh_highway_gen_if bus ();

  gh_highway_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .LANE_X0 (LX0), .LANE_PITCH (LP), .GEM_W (GW), .GEM_H (GH)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (en),
    .i_speed   (speed),
    .bus       (bus),
    .o_busy    (busy),
    .o_dropped (dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (pixel %0d)", tag, got, exp, m_p);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_gy[i]   = 0;
      m_busy[i] = 1'b0;
    end
    m_pend  = 1'b0;
    m_mask  = '0;
    m_drop  = 0;
    m_p     = 0;
    vde_cnt = 0;
    fs_cnt  = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_video", {bus.hsync, bus.vsync, bus.vde, bus.frame_start, bus.rgb}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_dropped", dropped, 32'd0);
    check("rst_ready", bus.note_ready, 32'd0);
  endtask

  // One pixel clock: expected output for the pixel just emitted, then the frame rules
  task automatic step();
    bit          s_en, s_valid, acc;
    bit [4:0]    s_mask;
    int          s_speed, x, y, x0;
    logic        e_hs, e_vs, e_vde, e_fs;
    logic [23:0] e_pix;
    logic [4:0]  e_busy;
    s_en    = en;
    s_valid = bus.note_valid;
    s_mask  = bus.note_mask;
    s_speed = int'(speed);
    @(posedge clk);
    #1;
    x     = m_p % HT;
    y     = m_p / HT;
    e_vde = (x < HA) && (y < VA);
    e_hs  = (x >= HA + HFP) && (x < HA + HFP + HSW);
    e_vs  = (y >= VA + VFP) && (y < VA + VFP + VSW);
    e_fs  = (m_p == 0);
    if (!e_vde) e_pix = 24'h0;
    else if (!s_en) e_pix = BG;
    else begin
      e_pix = BG;
      for (int i = 4; i >= 0; i--) begin
        x0 = LX0 + i * LP;
        if (m_busy[i] && x >= x0 && x < x0 + GW && y >= m_gy[i] && y < m_gy[i] + GH)
          e_pix = lane_rgb[i];
      end
    end
    check("video", {bus.hsync, bus.vsync, bus.vde, bus.frame_start, bus.rgb},
          {4'd0, e_hs, e_vs, e_vde, e_fs, e_pix});
    vde_cnt += int'(bus.vde);
    fs_cnt  += int'(bus.frame_start);

    acc = s_valid && s_en && !m_pend;
    if (m_p == FRAME - 1) begin
      if (!s_en) begin
        for (int i = 0; i < 5; i++) m_busy[i] = 1'b0;
      end else begin
        for (int i = 0; i < 5; i++) begin
          if (m_busy[i]) begin
            if (m_gy[i] + s_speed >= VA) m_busy[i] = 1'b0;
            else m_gy[i] = m_gy[i] + s_speed;
          end
          if (m_pend && m_mask[i]) begin
            if (m_busy[i]) begin
              if (m_drop < 255) m_drop++;
            end else begin
              m_busy[i] = 1'b1;
              m_gy[i]   = 0;
            end
          end
        end
      end
      m_pend = 1'b0;
    end
    if (acc) begin
      m_pend = 1'b1;
      m_mask = s_mask;
    end
    m_p = (m_p + 1) % FRAME;
    if (m_p == 0) begin
      check("vde_per_frame", vde_cnt, HA * VA);
      check("fs_per_frame", fs_cnt, 1);
      vde_cnt = 0;
      fs_cnt  = 0;
    end
    for (int i = 0; i < 5; i++) e_busy[i] = m_busy[i];
    check("busy", busy, e_busy);
    check("dropped", dropped, m_drop);
    check("ready", bus.note_ready, s_en && !m_pend);
  endtask

  // vprob: valid asserted with probability 1/vprob (0 = never)
  task automatic run(input int n, input int vprob, input logic [4:0] mask, input bit rand_mask);
    for (int k = 0; k < n; k++) begin
      bus.note_valid = (vprob > 0) && ($urandom_range(vprob - 1) == 0);
      bus.note_mask  = rand_mask ? 5'($urandom) : mask;
      step();
    end
    bus.note_valid = 1'b0;
  endtask

  task automatic request_on_boundary(input logic [4:0] mask);
    bus.note_valid = 1'b0;
    while (m_p != FRAME - 1) step();
    bus.note_valid = 1'b1;
    bus.note_mask  = mask;
    step();
    bus.note_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lane_rgb = '{24'h00FF00, 24'hFF0000, 24'hFFFF00, 24'h0000FF, 24'hFF8000};
    bus.note_valid = 1'b0;
    bus.note_mask  = '0;
    model_reset();

    en = 1'b1;
    #23;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // single green gem scrolling at one line per frame until it falls off
    speed = 4'd1;
    run(10, 0, 5'b0, 1'b0);
    run(1, 1, 5'b00001, 1'b0);
    run(14 * FRAME, 0, 5'b0, 1'b0);

    // frozen gem, second spawn on the same lane is dropped
    speed = 4'd0;
    run(1, 1, 5'b00001, 1'b0);
    run(FRAME, 0, 5'b0, 1'b0);
    run(1, 1, 5'b00001, 1'b0);
    run(2 * FRAME, 0, 5'b0, 1'b0);

    // held request while the slot is full, then a request exactly on the boundary
    run(FRAME + 20, 1, 5'b00110, 1'b0);
    request_on_boundary(5'b01000);
    run(2 * FRAME, 0, 5'b0, 1'b0);

    // three busy lanes, then enable dropped with requests refused
    speed = 4'd1;
    run(1, 1, 5'b00111, 1'b0);
    run(FRAME, 0, 5'b0, 1'b0);
    en = 1'b0;
    run(2 * FRAME, 4, 5'b0, 1'b1);
    en = 1'b1;

    for (int f = 0; f < 20; f++) begin
      speed = 4'($urandom_range(15));
      en    = ($urandom_range(7) != 0);
      run(FRAME, 40, 5'b0, 1'b1);
    end
    en = 1'b1;

    // asynchronous reset mid-line
    run(37, 0, 5'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    model_reset();
    rst_n = 1'b1;
    run(2 * FRAME, 30, 5'b0, 1'b1);

    // all lanes frozen, every boundary drops five until the counter saturates
    speed = 4'd0;
    run(55 * FRAME, 1, 5'b11111, 1'b0);
    check("dropped_sat", dropped, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
